// File: rtl/digit_serial_add_sub_pkg.sv
// Shared encodings for the digit-serial adder/subtractor: operation modes and FSM states.
package add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSUB = 2'b10,
    OP_BM2A = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/digit_serial_add_sub_if.sv
// Valid/ready transaction bus for digit_serial_add_sub; the slave modport is the block's view.
interface digit_serial_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cb;
  logic             ovf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cb, ovf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cb, ovf
  );
endinterface

// File: rtl/digit_serial_add_sub_digit_adder.sv
// DIGIT-bit ripple-carry adder made of chained full-adder cells.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/digit_serial_add_sub.sv
// Multi-cycle adder/subtractor: NDIG passes through one DIGIT-wide adder per transaction.
// Optional signed saturation of the result is enabled by defining DIGIT_SERIAL_ADD_SUB_SAT_EN.
module digit_serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  digit_serial_add_sub_if.slave bus
);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, result_q, result_d;
  logic             carry_q, carry_d, cb_q, cb_d, ovf_q, ovf_d;
  logic             s_q, s_d, so_q, so_d, xs_q, xs_d, ys_q, ys_d;
  op_e              op_q, op_d;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             last;
  logic [WIDTH-1:0] x_sel, y_sel, a_shl, sum_ext, sat_val;
  logic             ovf_run;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .x   (x_q[DIGIT-1:0]),
    .y   (y_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (dsum),
    .cout(dcout)
  );

  assign last = (idx_q == IDX_W'(NDIG - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cb_q     <= 1'b0;
      ovf_q    <= 1'b0;
      s_q      <= 1'b0;
      so_q     <= 1'b0;
      xs_q     <= 1'b0;
      ys_q     <= 1'b0;
      op_q     <= OP_ADD;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cb_q     <= cb_d;
      ovf_q    <= ovf_d;
      s_q      <= s_d;
      so_q     <= so_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    carry_d  = carry_q;
    cb_d     = cb_q;
    ovf_d    = ovf_q;
    s_d      = s_q;
    so_d     = so_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    op_d     = op_q;
    a_shl    = {bus.a[WIDTH-2:0], 1'b0};
    x_sel    = bus.a;
    y_sel    = bus.b;
    sum_ext  = '0;
    sum_ext[DIGIT-1:0] = dsum;
    sat_val  = xs_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    // Result MSB is the top bit of the digit being added on the last pass.
    ovf_run  = (xs_q == ys_q) && (dsum[DIGIT-1] != xs_q);

    unique case (op_e'(bus.op))
      OP_ADD:  begin x_sel = bus.a; y_sel = bus.b;   end
      OP_SUB:  begin x_sel = bus.a; y_sel = ~bus.b;  end
      OP_RSUB: begin x_sel = bus.b; y_sel = ~bus.a;  end
      OP_BM2A: begin x_sel = bus.b; y_sel = ~a_shl;  end
      default: begin x_sel = bus.a; y_sel = bus.b;   end
    endcase

    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d    = op_e'(bus.op);
        idx_d   = '0;
        x_d     = x_sel;
        y_d     = y_sel;
        xs_d    = x_sel[WIDTH-1];
        ys_d    = y_sel[WIDTH-1];
        carry_d = (op_e'(bus.op) != OP_ADD);
        s_d     = (op_e'(bus.op) == OP_BM2A) & bus.a[WIDTH-1];
        so_d    = (op_e'(bus.op) == OP_BM2A) & (bus.a[WIDTH-1] ^ bus.a[WIDTH-2]);
      end
      RUN: begin
        // Operands shift down so the adder always sees digit 0; result fills from the top.
        x_d      = x_q >> DIGIT;
        y_d      = y_q >> DIGIT;
        result_d = (result_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));
        carry_d  = dcout;
        idx_d    = idx_q + 1'b1;
        if (last) begin
          unique case (op_q)
            OP_ADD:  cb_d = dcout;
            OP_BM2A: cb_d = ~dcout | s_q;
            default: cb_d = ~dcout;
          endcase
          ovf_d = ovf_run | ((op_q == OP_BM2A) & so_q);
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
          if (ovf_d) result_d = sat_val;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
    bus.cb        = cb_q;
    bus.ovf       = ovf_q;
  end
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Self-checking bench for digit_serial_add_sub (WIDTH=16, DIGIT=4) against an arithmetic reference model.
module tb_digit_serial_add_sub;
  localparam int W = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  digit_serial_add_sub_if #(.WIDTH(W)) bus ();

  digit_serial_add_sub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit out_of_range(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Reference: true integer arithmetic, then reduce to WIDTH bits and flags.
  function automatic void ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                    input logic [1:0] rop, output logic [15:0] r,
                                    output logic rc, output logic rv);
    longint ua, ub, sa, sb, full, sfull, a2w;
    logic [15:0] twice;
    logic        xsign;
    ua = longint'(ra);
    ub = longint'(rb);
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    full = 0; rc = 0; rv = 0; xsign = ra[15];
    case (rop)
      2'd0: begin full = ua + ub; rc = (full >= 65536); rv = out_of_range(sa + sb); end
      2'd1: begin full = ua - ub; rc = (ua < ub); rv = out_of_range(sa - sb); end
      2'd2: begin full = ub - ua; rc = (ub < ua); rv = out_of_range(sb - sa); xsign = rb[15]; end
      default: begin
        full  = ub - 2 * ua;
        rc    = (ub < 2 * ua);
        twice = ra << 1;
        a2w   = longint'($signed(twice));
        sfull = sb - a2w;
        rv    = out_of_range(2 * sa) || out_of_range(sfull);
        xsign = rb[15];
      end
    endcase
    r = full[15:0];
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
    if (rv) r = xsign ? 16'h8000 : 16'h7FFF;
`endif
  endfunction

  // Drives one transaction from IDLE and collects outputs; lat=-1 if out_valid never rose.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] top,
                         output logic [15:0] r, output logic rc, output logic rv,
                         output int lat, output int busy);
    bit got;
    @(negedge clk);
    bus.a = ta; bus.b = tb_; bus.op = top; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = -1; busy = 0; got = 0;
    for (int i = 1; i <= 20; i++) begin
      if (!got) begin
        @(posedge clk); #1;
        if (bus.out_valid) begin lat = i; got = 1; end
        else if (bus.in_ready) busy++;
      end
    end
    r = bus.result; rc = bus.cb; rv = bus.ovf;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 16'h0 ||
        bus.cb !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h cb=%b ovf=%b, required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.cb, bus.ovf);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [7], tbv [7], er [7];
    logic [1:0]  to [7];
    logic        ec [7], ev [7];
    logic [15:0] r;
    logic        rc, rv;
    int          lat, busy;
    ta = '{16'd23, 16'd21, 16'd21, 16'd16800, 16'd256, 16'd45, 16'h8000};
    tbv = '{16'd3, 16'd75, 16'd75, 16'd16900, 16'd5, 16'd135, 16'd100};
    to = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11};
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
    er = '{16'd26, 16'hFFCA, 16'd54, 16'h7FFF, 16'd65029, 16'd45, 16'h7FFF};
`else
    er = '{16'd26, 16'hFFCA, 16'd54, 16'd33700, 16'd65029, 16'd45, 16'd100};
`endif
    ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_txn(ta[i], tbv[i], to[i], r, rc, rv, lat, busy);
      checks++;
      if (r !== er[i] || rc !== ec[i] || rv !== ev[i]) begin
        errors++;
        $display("FAIL directed_%0d: result=%h cb=%b ovf=%b, required %h %b %b",
                 i, r, rc, rv, er[i], ec[i], ev[i]);
      end
      checks++;
      if (lat !== 4 || busy !== 0) begin
        errors++;
        $display("FAIL latency_%0d: latency=%0d ready_in_run=%0d, required 4 0", i, lat, busy);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] ta, tbv, r, er;
    logic [1:0]  to;
    logic        rc, rv, ec, ev;
    int          lat, busy;
    logic [15:0] edges [6];
    edges = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h4000, 16'hC000};
    for (int i = 0; i < 40; i++) begin
      ta  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      tbv = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      to  = 2'($urandom_range(0, 3));
      ref_model(ta, tbv, to, er, ec, ev);
      run_txn(ta, tbv, to, r, rc, rv, lat, busy);
      checks++;
      if (r !== er || rc !== ec || rv !== ev || lat !== 4) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h cb=%b ovf=%b lat=%0d, required %h %b %b 4",
                 i, to, ta, tbv, r, rc, rv, lat, er, ec, ev);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] r, er;
    logic        rc, rv, ec, ev;
    int          lat, busy;
    bit          got;
    @(negedge clk);
    bus.a = 16'd1000; bus.b = 16'd234; bus.op = 2'b00; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (!got) begin
        @(posedge clk); #1;
        got = bus.out_valid;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_valid_timeout: out_valid=%b, required 1", bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 16'd1234 || bus.cb !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b result=%0d cb=%b in_ready=%b, required 1 1234 0 0",
                 i, bus.out_valid, bus.result, bus.cb, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 16'd1234 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b result=%0d in_ready=%b, required 0 1234 1",
               bus.out_valid, bus.result, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_stray_accept: in_ready=%b, required 1", bus.in_ready);
    end
    ref_model(16'd40000, 16'd123, 2'b01, er, ec, ev);
    run_txn(16'd40000, 16'd123, 2'b01, r, rc, rv, lat, busy);
    checks++;
    if (r !== er || rc !== ec || rv !== ev || lat !== 4) begin
      errors++;
      $display("FAIL bp_next_txn: result=%h cb=%b ovf=%b lat=%0d, required %h %b %b 4",
               r, rc, rv, lat, er, ec, ev);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] r;
    logic        rc, rv;
    int          lat, busy;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h4321; bus.op = 2'b00; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h, required 1 0 0000",
               bus.in_ready, bus.out_valid, bus.result);
    end
    #2 reset = 1'b0;
    run_txn(16'd1, 16'd1, 2'b00, r, rc, rv, lat, busy);
    checks++;
    if (r !== 16'd2 || rc !== 1'b0 || rv !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL post_reset_txn: result=%0d cb=%b ovf=%b lat=%0d, required 2 0 0 4", r, rc, rv, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
